// File: rtl/misp_control_fsm.sv
//------------------------------------------------------------------------------
// Module   : misp_control_fsm
// Purpose  : Multicycle control sequencer for the 16-bit MISP core. Steps
//            FETCH/DECODE/EXECUTE/MEM/WRITEBACK from IR[15:12], drives every
//            datapath select/enable, and runs a handshaked I/O port with a
//            bounded wait.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module misp_control_fsm #(
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       io_ack,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       io_req,
  output logic       io_we,
  output logic       halted,
  output logic       io_timeout,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_IO_REQ   = 4'd13,
    S_IO_WB    = 4'd14,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [3:0] C_OP_ADDI = 4'b0100;
  localparam logic [3:0] C_OP_LW   = 4'b0101;
  localparam logic [3:0] C_OP_SW   = 4'b0110;
  localparam logic [3:0] C_OP_BEQ  = 4'b0111;
  localparam logic [3:0] C_OP_JMP  = 4'b1000;
  localparam logic [3:0] C_OP_IN   = 4'b1001;
  localparam logic [3:0] C_OP_OUT  = 4'b1010;
  localparam logic [3:0] C_OP_HALT = 4'b1111;

  // Last wait count: reaching IO_TIMEOUT waiting cycles aborts the request.
  localparam logic [7:0] C_TMO_LAST = 8'(IO_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tmo_d;
  logic       ill_d;

  logic       pc_write_d, pc_write_cond_d, i_or_d_d, mem_read_d, mem_write_d;
  logic       ir_write_d, reg_dst_d, reg_write_d, io_req_d, io_we_d, halted_d;
  logic [1:0] mem_to_reg_d, alu_src_a_d, alu_src_b_d, alu_op_d, pc_source_d;

  // The zero flag qualifies the conditional PC load inside the datapath;
  // the sequencer itself never needs to look at it.
  logic unused_zero;
  assign unused_zero = zero;

  assign state = state_q;

  // Next-state, I/O wait counter, sticky timeout and illegal-opcode pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = io_timeout;
    ill_d   = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'b0000, 4'b0001,
          4'b0010, 4'b0011:  state_d = S_EXEC_R;
          C_OP_ADDI:         state_d = S_EXEC_I;
          C_OP_LW, C_OP_SW:  state_d = S_MEM_ADDR;
          C_OP_BEQ:          state_d = S_BRANCH;
          C_OP_JMP:          state_d = S_JUMP;
          C_OP_IN, C_OP_OUT: state_d = S_IO_REQ;
          C_OP_HALT:         state_d = S_HALT;
          default: begin
            ill_d   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     state_d = S_FETCH;
      S_MEM_ADDR: state_d = (opcode == C_OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_IO_REQ: begin
        // An acknowledge in the final allowed cycle still completes normally.
        if (io_ack) begin
          cnt_d   = 8'd0;
          state_d = (opcode == C_OP_IN) ? S_IO_WB : S_FETCH;
        end else if (cnt_q == C_TMO_LAST) begin
          cnt_d   = 8'd0;
          tmo_d   = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      S_IO_WB:  state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore output decode of the state being entered, so outputs can be registered.
  always_comb begin
    pc_write_d      = 1'b0;
    pc_write_cond_d = 1'b0;
    i_or_d_d        = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    ir_write_d      = 1'b0;
    reg_dst_d       = 1'b0;
    reg_write_d     = 1'b0;
    mem_to_reg_d    = 2'b00;
    alu_src_a_d     = 2'b00;
    alu_src_b_d     = 2'b00;
    alu_op_d        = 2'b00;
    pc_source_d     = 2'b00;
    io_req_d        = 1'b0;
    io_we_d         = 1'b0;
    halted_d        = 1'b0;
    case (state_d)
      S_FETCH: begin
        mem_read_d  = 1'b1;
        ir_write_d  = 1'b1;
        alu_src_b_d = 2'b01;
        pc_write_d  = 1'b1;
      end
      S_DECODE:   alu_src_b_d = 2'b10;
      S_EXEC_R: begin
        alu_src_a_d = 2'b01;
        alu_op_d    = 2'b10;
      end
      S_WB_R: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b10;
      end
      S_WB_I:     reg_write_d = 1'b1;
      S_MEM_RD: begin
        mem_read_d = 1'b1;
        i_or_d_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 2'b01;
      end
      S_MEM_WR: begin
        mem_write_d = 1'b1;
        i_or_d_d    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_d     = 2'b01;
        alu_op_d        = 2'b01;
        pc_write_cond_d = 1'b1;
        pc_source_d     = 2'b01;
      end
      S_JUMP: begin
        pc_write_d  = 1'b1;
        pc_source_d = 2'b10;
      end
      S_IO_REQ: begin
        io_req_d = 1'b1;
        io_we_d  = (opcode == C_OP_OUT);
      end
      S_IO_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 2'b10;
      end
      S_HALT:     halted_d = 1'b1;
      default:    ;
    endcase
  end

  // State, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      pc_write      <= 1'b0;
      pc_write_cond <= 1'b0;
      i_or_d        <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      ir_write      <= 1'b0;
      reg_dst       <= 1'b0;
      reg_write     <= 1'b0;
      mem_to_reg    <= 2'b00;
      alu_src_a     <= 2'b00;
      alu_src_b     <= 2'b00;
      alu_op        <= 2'b00;
      pc_source     <= 2'b00;
      io_req        <= 1'b0;
      io_we         <= 1'b0;
      halted        <= 1'b0;
      io_timeout    <= 1'b0;
      illegal_op    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pc_write      <= pc_write_d;
      pc_write_cond <= pc_write_cond_d;
      i_or_d        <= i_or_d_d;
      mem_read      <= mem_read_d;
      mem_write     <= mem_write_d;
      ir_write      <= ir_write_d;
      reg_dst       <= reg_dst_d;
      reg_write     <= reg_write_d;
      mem_to_reg    <= mem_to_reg_d;
      alu_src_a     <= alu_src_a_d;
      alu_src_b     <= alu_src_b_d;
      alu_op        <= alu_op_d;
      pc_source     <= pc_source_d;
      io_req        <= io_req_d;
      io_we         <= io_we_d;
      halted        <= halted_d;
      io_timeout    <= tmo_d;
      illegal_op    <= ill_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_misp_control_fsm.sv
//------------------------------------------------------------------------------
// Module   : tb_misp_control_fsm
// Purpose  : Self-checking bench for misp_control_fsm (IO_TIMEOUT = 4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_misp_control_fsm;

  logic       clk, reset_n, zero, io_ack;
  logic [3:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, reg_write, io_req, io_we, halted, io_timeout, illegal_op;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  misp_control_fsm #(.IO_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .io_ack(io_ack),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .io_req(io_req), .io_we(io_we), .halted(halted),
    .io_timeout(io_timeout), .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [22:0] act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                     pc_source, io_req, io_we, halted, io_timeout, illegal_op};

  typedef struct packed {
    logic [3:0]  st;
    logic [22:0] o;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  logic  exp_tmo;
  string cur;

  // Reference output table for each state, written from the state/output list.
  function automatic logic [22:0] model(input logic [3:0] st, input logic [3:0] op,
                                        input logic tmo, input logic ill);
    logic pw, pwc, iod, mr, mw, irw, rd, rw, ioreq, iowe, hlt;
    logic [1:0] m2r, asa, asb, aop, psrc;
    {pw, pwc, iod, mr, mw, irw, rd, rw, ioreq, iowe, hlt} = '0;
    {m2r, asa, asb, aop, psrc} = '0;
    case (st)
      4'd1:  begin mr = 1; irw = 1; asb = 2'b01; pw = 1; end
      4'd2:  asb = 2'b10;
      4'd3:  begin asa = 2'b01; asb = 2'b00; aop = 2'b10; end
      4'd4:  begin rd = 1; rw = 1; end
      4'd5:  begin asa = 2'b01; asb = 2'b10; end
      4'd6:  rw = 1;
      4'd7:  begin asa = 2'b01; asb = 2'b10; end
      4'd8:  begin mr = 1; iod = 1; end
      4'd9:  begin rw = 1; m2r = 2'b01; end
      4'd10: begin mw = 1; iod = 1; end
      4'd11: begin asa = 2'b01; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      4'd12: begin pw = 1; psrc = 2'b10; end
      4'd13: begin ioreq = 1; iowe = (op == 4'b1010); end
      4'd14: begin rw = 1; m2r = 2'b10; end
      4'd15: hlt = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, rd, rw, m2r, asa, asb, aop, psrc,
            ioreq, iowe, hlt, tmo, ill};
  endfunction

  task automatic push(input logic [3:0] st, input logic ill);
    exp_t e;
    e.st = st;
    e.o  = model(st, opcode, exp_tmo, ill);
    q.push_back(e);
  endtask

  // Advance one clock and compare the DUT against the oldest scoreboard entry.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue, required an entry", cur);
    end else begin
      e = q.pop_front();
      if (state !== e.st) begin
        errors++;
        $display("FAIL %s state: got %0d required %0d", cur, state, e.st);
      end
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL %s outputs (st %0d): got %h required %h", cur, e.st, act, e.o);
      end
    end
  endtask

  task automatic drain();
    while (q.size() > 0) step();
  endtask

  task automatic test_reset();
    cur = "reset";
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL reset state: got %0d required 0", state);
    end
    checks++;
    if (act !== 23'd0) begin
      errors++; $display("FAIL reset outputs: got %h required 0", act);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_rtype(input logic [3:0] op);
    cur = "rtype";
    opcode = op;
    push(4'd1, 0); push(4'd2, 0); push(4'd3, 0); push(4'd4, 0);
    drain();
  endtask

  task automatic test_addi();
    cur = "addi";
    opcode = 4'b0100;
    push(4'd1, 0); push(4'd2, 0); push(4'd5, 0); push(4'd6, 0);
    drain();
  endtask

  task automatic test_lw();
    cur = "lw";
    opcode = 4'b0101;
    push(4'd1, 0); push(4'd2, 0); push(4'd7, 0); push(4'd8, 0); push(4'd9, 0);
    drain();
  endtask

  task automatic test_sw();
    cur = "sw";
    opcode = 4'b0110;
    push(4'd1, 0); push(4'd2, 0); push(4'd7, 0); push(4'd10, 0);
    drain();
  endtask

  task automatic test_beq(input logic z);
    cur = z ? "beq_z1" : "beq_z0";
    opcode = 4'b0111;
    zero = z;
    push(4'd1, 0); push(4'd2, 0); push(4'd11, 0);
    drain();
    zero = 1'b0;
  endtask

  task automatic test_jmp();
    cur = "jmp";
    opcode = 4'b1000;
    push(4'd1, 0); push(4'd2, 0); push(4'd12, 0);
    drain();
  endtask

  // IN acknowledged in the 4th request cycle: the same cycle the wait count
  // reaches the limit, so the acknowledge must win.
  task automatic test_in_late_ack();
    cur = "in_late_ack";
    opcode = 4'b1001;
    io_ack = 1'b0;
    push(4'd1, 0); push(4'd2, 0); push(4'd13, 0);
    drain();
    repeat (3) begin push(4'd13, 0); step(); end
    io_ack = 1'b1;
    push(4'd14, 0);
    step();
    io_ack = 1'b0;
  endtask

  task automatic test_out_timeout();
    cur = "out_timeout";
    opcode = 4'b1010;
    io_ack = 1'b0;
    push(4'd1, 0); push(4'd2, 0);
    repeat (4) push(4'd13, 0);
    drain();
    exp_tmo = 1'b1;
  endtask

  task automatic test_illegal();
    cur = "illegal";
    opcode = 4'b1100;
    push(4'd1, 0); push(4'd2, 0); push(4'd1, 1);
    drain();
    opcode = 4'b1000;
    push(4'd2, 0); push(4'd12, 0);
    drain();
  endtask

  task automatic test_io_min_latency();
    cur = "io_min_latency";
    opcode = 4'b1001;
    push(4'd1, 0); push(4'd2, 0);
    drain();
    io_ack = 1'b1;
    push(4'd13, 0); push(4'd14, 0);
    drain();
    io_ack = 1'b0;
  endtask

  task automatic test_halt();
    cur = "halt";
    opcode = 4'b1111;
    push(4'd1, 0); push(4'd2, 0); push(4'd15, 0);
    drain();
    for (int i = 0; i < 100; i++) begin
      io_ack = 1'($urandom_range(0, 1));
      push(4'd15, 0);
      step();
    end
    io_ack = 1'b0;
  endtask

  task automatic test_reset_mid_io();
    cur = "reset_from_halt";
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({state, act} !== 27'd0) begin
      errors++; $display("FAIL %s: got st %0d out %h required 0/0", cur, state, act);
    end
    exp_tmo = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cur = "reset_mid_io";
    opcode = 4'b1010;
    push(4'd1, 0); push(4'd2, 0); push(4'd13, 0); push(4'd13, 0);
    drain();
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (io_req !== 1'b0 || state !== 4'd0) begin
      errors++;
      $display("FAIL %s: got io_req %b state %0d required 0 0", cur, io_req, state);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    opcode  = 4'd0;
    zero    = 1'b0;
    io_ack  = 1'b0;
    exp_tmo = 1'b0;
    cur     = "init";
    test_reset();
    test_rtype(4'b0000);
    test_rtype(4'b0011);
    test_addi();
    test_lw();
    test_sw();
    test_beq(1'b0);
    test_beq(1'b1);
    test_jmp();
    test_in_late_ack();
    test_io_min_latency();
    test_out_timeout();
    test_rtype(4'b0001);
    test_illegal();
    test_halt();
    test_reset_mid_io();
    test_jmp();
    test_in_late_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
